tetris_board: RTL

//  Game-state engine feeding color_mapper. Owns the 10x20 locked-cell array and one

---
 rtl/tetris_board.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_board.sv
// Game-state engine for a 10x20 falling-block board.
// Holds the locked-cell array and one active piece. The FSM handles spawn, gravity,
// horizontal and soft-drop moves, locking, row scan/clear and game over.
// grid[x][y] is combinational: locked cells, plus the active piece in FALL and LOCK.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_SPAWN | latch the next piece type, place its anchor at (SPAWN_X,0), test for collision
// S_FALL  | piece is live: gravity, left/right, soft drop (at most one action per cycle)
// S_LOCK  | copy the piece's four cells into the locked array
// S_SCAN  | test row scan_r for fullness, walking from row 19 up to row 0
// S_SHIFT | drop rows 0..scan_r-1 down by one row, clear row 0, count the line
// S_OVER  | terminal until reset; inputs ignored, grid shows locked cells only

module tetris_board #(
    parameter int GRAVITY_FRAMES = 30,
    parameter int SPAWN_X        = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_tick,
    input  logic                  move_left,
    input  logic                  move_right,
    input  logic                  soft_drop,
    input  logic [2:0]            piece_sel,
    output logic [9:0][19:0][3:0] grid,
    output logic                  game_over,
    output logic [15:0]           lines_cleared
);

    localparam int CNT_W = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_FRAMES - 1);

    typedef enum logic [2:0] {
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_SCAN,
        S_SHIFT,
        S_OVER
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [9:0][19:0][3:0] locked;
    logic [2:0]            ptype;
    logic [3:0]            ax;
    logic [4:0]            ay;
    logic [CNT_W-1:0]      cnt;
    logic [4:0]            scan_r;

    logic [2:0]  sel_type;
    logic [3:0]  colour;
    logic [11:0] piece_shape;
    logic [3:0]  piece_x [4];
    logic [4:0]  piece_y [4];
    logic        down_req;
    logic        blk_spawn;
    logic        blk_left;
    logic        blk_right;
    logic        blk_down;
    logic        row_full;

    // Cell offsets for one piece type, four 3-bit fields {dx[1:0], dy}; cell 0 in bits [2:0].
    function automatic logic [11:0] shape_cells(input logic [2:0] t);
        logic [11:0] s;
        case (t)
            3'd1:    s = {3'b011, 3'b001, 3'b010, 3'b000};  // O
            3'd2:    s = {3'b011, 3'b100, 3'b010, 3'b000};  // T
            3'd3:    s = {3'b011, 3'b001, 3'b100, 3'b010};  // S
            3'd4:    s = {3'b101, 3'b011, 3'b010, 3'b000};  // Z
            3'd5:    s = {3'b101, 3'b100, 3'b010, 3'b000};  // J
            3'd6:    s = {3'b001, 3'b100, 3'b010, 3'b000};  // L
            default: s = {3'b110, 3'b100, 3'b010, 3'b000};  // I (types 0 and 7)
        endcase
        return s;
    endfunction

    // A candidate anchor is blocked if any cell leaves the board or hits a locked cell.
    // Coordinates are one bit wider than the board so ax+dx and ay+dy never wrap,
    // and an anchor of 0 minus 1 wraps to 31, which reads as off-board.
    function automatic logic is_blocked(input logic [2:0]            t,
                                        input logic [4:0]            cx,
                                        input logic [5:0]            cy,
                                        input logic [9:0][19:0][3:0] cells);
        logic [11:0] s;
        logic [4:0]  x;
        logic [5:0]  y;
        logic        blk;
        s   = shape_cells(t);
        blk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = cx + {3'b000, s[3*i+1 +: 2]};
            y = cy + {5'b00000, s[3*i]};
            if (x > 5'd9 || y > 6'd19) begin
                blk = 1'b1;
            end else if (cells[x[3:0]][y[4:0]] != 4'd0) begin
                blk = 1'b1;
            end
        end
        return blk;
    endfunction

    assign sel_type    = (piece_sel == 3'd7) ? 3'd0 : piece_sel;
    assign colour      = {1'b0, ptype} + 4'd1;
    assign piece_shape = shape_cells(ptype);
    assign down_req    = soft_drop | (frame_tick & (cnt == CNT_LAST));
    assign game_over   = (state == S_OVER);

    // Board coordinates of the active piece's four cells.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            piece_x[i] = ax + {2'b00, piece_shape[3*i+1 +: 2]};
            piece_y[i] = ay + {4'b0000, piece_shape[3*i]};
        end
    end

    // Collision tests for spawn and the three possible moves, plus the full-row test.
    always_comb begin
        blk_spawn = is_blocked(sel_type, 5'(SPAWN_X), 6'd0, locked);
        blk_left  = is_blocked(ptype, {1'b0, ax} - 5'd1, {1'b0, ay}, locked);
        blk_right = is_blocked(ptype, {1'b0, ax} + 5'd1, {1'b0, ay}, locked);
        blk_down  = is_blocked(ptype, {1'b0, ax}, {1'b0, ay} + 6'd1, locked);
        row_full  = 1'b1;
        for (int x = 0; x < 10; x++) begin
            if (locked[x][scan_r] == 4'd0) begin
                row_full = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_SPAWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SPAWN: state_nxt = blk_spawn ? S_OVER : S_FALL;
            S_FALL:  if (down_req && blk_down) state_nxt = S_LOCK;
            S_LOCK:  state_nxt = S_SCAN;
            S_SCAN: begin
                if (row_full) begin
                    state_nxt = S_SHIFT;
                end else if (scan_r == 5'd0) begin
                    state_nxt = S_SPAWN;
                end
            end
            S_SHIFT: state_nxt = S_SCAN;
            S_OVER:  state_nxt = S_OVER;
            default: state_nxt = S_SPAWN;
        endcase
    end

    // Piece position, gravity counter, locked array, scan row and line counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            locked        <= '0;
            ptype         <= 3'd0;
            ax            <= 4'd0;
            ay            <= 5'd0;
            cnt           <= '0;
            scan_r        <= 5'd0;
            lines_cleared <= 16'd0;
        end else begin
            case (state)
                S_SPAWN: begin
                    ptype <= sel_type;
                    ax    <= 4'(SPAWN_X);
                    ay    <= 5'd0;
                    cnt   <= '0;
                end
                S_FALL: begin
                    if (down_req) begin
                        // A horizontal request in the same cycle is dropped.
                        cnt <= '0;
                        if (!blk_down) begin
                            ay <= ay + 5'd1;
                        end
                    end else begin
                        if (frame_tick) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (move_left && !move_right && !blk_left) begin
                            ax <= ax - 4'd1;
                        end else if (move_right && !move_left && !blk_right) begin
                            ax <= ax + 4'd1;
                        end
                    end
                end
                S_LOCK: begin
                    for (int i = 0; i < 4; i++) begin
                        locked[piece_x[i]][piece_y[i]] <= colour;
                    end
                    scan_r <= 5'd19;
                end
                S_SCAN: begin
                    if (!row_full && scan_r != 5'd0) begin
                        scan_r <= scan_r - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // scan_r is kept so the row that moved down gets rescanned.
                    for (int y = 0; y < 20; y++) begin
                        for (int x = 0; x < 10; x++) begin
                            if (y == 0) begin
                                locked[x][y] <= 4'd0;
                            end else if (5'(y) <= scan_r) begin
                                locked[x][y] <= locked[x][y-1];
                            end
                        end
                    end
                    lines_cleared <= lines_cleared + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Display: locked cells with the active piece overlaid while it is on the board.
    always_comb begin
        grid = locked;
        if (state == S_FALL || state == S_LOCK) begin
            for (int i = 0; i < 4; i++) begin
                if (piece_x[i] <= 4'd9 && piece_y[i] <= 5'd19) begin
                    grid[piece_x[i]][piece_y[i]] = colour;
                end
            end
        end
    end

endmodule
